// File: rtl/sweep_sequencer.sv
// Stepped-frequency sweep sequencer: load DDS word, settle, measure, hand result to SPI readback.
// One FSM walks the points; all outputs are registered.
module sweep_sequencer #(
    parameter int FW_W    = 32,
    parameter int MEAS_W  = 32,
    parameter int IDX_W   = 16,
    parameter int CNT_W   = 24,
    parameter int MEAS_TO = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FW_W-1:0]   f_start,
    input  logic [FW_W-1:0]   f_step,
    input  logic [IDX_W-1:0]  n_points,
    input  logic [CNT_W-1:0]  settle_cyc,
    output logic [FW_W-1:0]   fword,
    output logic              fword_load,
    output logic              meas_req,
    input  logic              meas_ack,
    input  logic [MEAS_W-1:0] meas_amp,
    input  logic [MEAS_W-1:0] meas_phase,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [FW_W-1:0]   res_fword,
    output logic [MEAS_W-1:0] res_amp,
    output logic [MEAS_W-1:0] res_phase,
    output logic              res_err,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int TO_W = $clog2(MEAS_TO + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        MEAS,
        OUT,
        FIN
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [FW_W-1:0]   fword;
        logic [MEAS_W-1:0] amp;
        logic [MEAS_W-1:0] phase;
        logic              err;
    } res_t;

    state_t            state, state_n;
    logic [FW_W-1:0]   cur_f;
    logic [FW_W-1:0]   step_q;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  settle_q;
    logic [CNT_W-1:0]  settle_cnt;
    logic [TO_W-1:0]   to_cnt;
    res_t              res_q;

    logic abort_take;
    logic last;
    logic timeout;
    logic hs;

    assign abort_take = abort && (state != IDLE);
    assign last       = (idx == n_q - IDX_W'(1));
    assign timeout    = (to_cnt == TO_W'(MEAS_TO - 1));
    assign hs         = res_valid && res_ready;

    assign res_idx   = res_q.idx;
    assign res_fword = res_q.fword;
    assign res_amp   = res_q.amp;
    assign res_phase = res_q.phase;
    assign res_err   = res_q.err;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (n_points == '0) ? FIN : LOAD;
            LOAD:    state_n = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_n = MEAS;
            MEAS:    if (meas_ack || timeout) state_n = OUT;
            OUT:     if (hs) state_n = last ? FIN : LOAD;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_take) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_f      <= '0;
            step_q     <= '0;
            n_q        <= '0;
            idx        <= '0;
            settle_q   <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            res_q      <= '0;
            fword      <= '0;
            fword_load <= 1'b0;
            meas_req   <= 1'b0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != IDLE);
            fword_load <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            // fword is left alone on abort: the DDS is still running it
            if (abort_take) begin
                meas_req  <= 1'b0;
                res_valid <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cur_f    <= f_start;
                            step_q   <= f_step;
                            n_q      <= n_points;
                            settle_q <= settle_cyc;
                            idx      <= '0;
                        end
                    end
                    LOAD: begin
                        fword      <= cur_f;
                        fword_load <= 1'b1;
                        settle_cnt <= settle_q;
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            meas_req <= 1'b1;
                            to_cnt   <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end
                    end
                    MEAS: begin
                        if (meas_ack) begin
                            meas_req  <= 1'b0;
                            res_valid <= 1'b1;
                            res_q     <= '{idx: idx, fword: cur_f, amp: meas_amp,
                                           phase: meas_phase, err: 1'b0};
                        end else if (timeout) begin
                            meas_req  <= 1'b0;
                            res_valid <= 1'b1;
                            res_q     <= '{idx: idx, fword: cur_f, amp: '0,
                                           phase: '0, err: 1'b1};
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    OUT: begin
                        if (hs) begin
                            res_valid <= 1'b0;
                            if (!last) begin
                                idx   <= idx + IDX_W'(1);
                                cur_f <= cur_f + step_q;
                            end
                        end
                    end
                    FIN:     done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_sweep_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_points;
    logic [23:0] settle_cyc;
    logic [31:0] fword;
    logic        fword_load;
    logic        meas_req;
    logic        meas_ack;
    logic [31:0] meas_amp;
    logic [31:0] meas_phase;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_idx;
    logic [31:0] res_fword;
    logic [31:0] res_amp;
    logic [31:0] res_phase;
    logic        res_err;
    logic        busy;
    logic        done;
    logic        aborted;

    int checks   = 0;
    int failures = 0;

    sweep_sequencer #(.MEAS_TO(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points), .settle_cyc(settle_cyc),
        .fword(fword), .fword_load(fword_load), .meas_req(meas_req),
        .meas_ack(meas_ack), .meas_amp(meas_amp), .meas_phase(meas_phase),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_fword(res_fword), .res_amp(res_amp), .res_phase(res_phase),
        .res_err(res_err), .busy(busy), .done(done), .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives start for one cycle; returns on the falling edge after the sampling edge.
    task automatic do_start(input logic [31:0] fs, input logic [31:0] fst,
                            input logic [15:0] n, input logic [23:0] s);
        f_start = fs; f_step = fst; n_points = n; settle_cyc = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, aborted, fword_load, meas_req, res_valid, res_err} !== 7'b0 ||
            fword !== 32'h0 || res_fword !== 32'h0 || res_idx !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: flags=%b fword=%h res_fword=%h res_idx=%h, required all zero",
                     {busy, done, aborted, fword_load, meas_req, res_valid, res_err},
                     fword, res_fword, res_idx);
        end
        rst = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort: aborted=%b busy=%b, required 0 0", aborted, busy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ef;
        res_ready = 1'b1;
        do_start(32'h1000, 32'h100, 16'd3, 24'd4);
        checks++;
        if (fword_load !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_after_start: fword_load=%b busy=%b, required 0 1", fword_load, busy);
        end
        for (int p = 0; p < 3; p++) begin
            ef = 32'h1000 + 32'(p) * 32'h100;
            @(negedge clk);
            checks++;
            if ({fword_load, fword} !== {1'b1, ef}) begin
                failures++;
                $display("FAIL t1_load%0d: fword_load=%b fword=%h, required 1 %h", p, fword_load, fword, ef);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (meas_req !== 1'b0) begin
                failures++;
                $display("FAIL t1_req_early%0d: meas_req=%b, required 0", p, meas_req);
            end
            @(negedge clk);
            checks++;
            if (meas_req !== 1'b1) begin
                failures++;
                $display("FAIL t1_req_rise%0d: meas_req=%b, required 1", p, meas_req);
            end
            @(negedge clk);
            meas_ack = 1'b1; meas_amp = 32'hA000 + 32'(p); meas_phase = 32'hB000 + 32'(p);
            @(negedge clk);
            meas_ack = 1'b0;
            checks++;
            if ({res_valid, meas_req, res_err, res_idx, res_fword, res_amp, res_phase} !==
                {1'b1, 1'b0, 1'b0, 16'(p), ef, 32'hA000 + 32'(p), 32'hB000 + 32'(p)}) begin
                failures++;
                $display("FAIL t1_result%0d: v=%b req=%b err=%b idx=%0d fw=%h amp=%h ph=%h, required 1 0 0 %0d %h %h %h",
                         p, res_valid, meas_req, res_err, res_idx, res_fword, res_amp, res_phase,
                         p, ef, 32'hA000 + 32'(p), 32'hB000 + 32'(p));
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL t1_post_hs%0d: res_valid=%b done=%b, required 0 0", p, res_valid, done);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL t1_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL t1_done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_zero_points();
        do_start(32'h2000, 32'h1, 16'd0, 24'd4);
        checks++;
        if ({busy, fword_load, done} !== 3'b100) begin
            failures++;
            $display("FAIL t2_fin: busy=%b fword_load=%b done=%b, required 1 0 0", busy, fword_load, done);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, fword_load, res_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL t2_done: done=%b busy=%b fword_load=%b res_valid=%b, required 1 0 0 0",
                     done, busy, fword_load, res_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL t2_done_once: done=%b, required 0", done);
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        do_start(32'h3000, 32'h10, 16'd2, 24'd0);
        @(negedge clk);
        @(negedge clk);
        meas_ack = 1'b1; meas_amp = 32'h1234; meas_phase = 32'h5678;
        @(negedge clk);
        meas_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin meas_ack = 1'b1; meas_amp = 32'hDEAD; meas_phase = 32'hBEEF; end
            if (k == 4) meas_ack = 1'b0;
            if (k == 5) begin start = 1'b1; f_start = 32'h9999; f_step = 32'h7; n_points = 16'd9; end
            if (k == 6) start = 1'b0;
            checks++;
            if ({res_valid, fword_load, meas_req, res_idx, res_fword, res_amp, res_phase} !==
                {1'b1, 1'b0, 1'b0, 16'd0, 32'h3000, 32'h1234, 32'h5678}) begin
                failures++;
                $display("FAIL t3_hold%0d: v=%b load=%b req=%b idx=%0d fw=%h amp=%h ph=%h, required 1 0 0 0 3000 1234 5678",
                         k, res_valid, fword_load, meas_req, res_idx, res_fword, res_amp, res_phase);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL t3_hs: res_valid=%b, required 0", res_valid);
        end
        @(negedge clk);
        checks++;
        if ({fword_load, fword} !== {1'b1, 32'h3010}) begin
            failures++;
            $display("FAIL t3_next_load: fword_load=%b fword=%h, required 1 3010", fword_load, fword);
        end
        @(negedge clk);
        meas_ack = 1'b1; meas_amp = 32'h11; meas_phase = 32'h22;
        @(negedge clk);
        meas_ack = 1'b0;
        checks++;
        if ({res_valid, res_idx, res_amp} !== {1'b1, 16'd1, 32'h11}) begin
            failures++;
            $display("FAIL t3_result1: v=%b idx=%0d amp=%h, required 1 1 11", res_valid, res_idx, res_amp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL t3_done: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    task automatic test_timeout();
        res_ready = 1'b1;
        do_start(32'h4000, 32'h40, 16'd2, 24'd0);
        @(negedge clk);
        @(negedge clk);
        repeat (15) @(negedge clk);
        checks++;
        if ({meas_req, res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL t4_still_waiting: meas_req=%b res_valid=%b, required 1 0", meas_req, res_valid);
        end
        @(negedge clk);
        checks++;
        if ({res_valid, res_err, meas_req, res_idx, res_fword, res_amp, res_phase} !==
            {1'b1, 1'b1, 1'b0, 16'd0, 32'h4000, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL t4_timeout: v=%b err=%b req=%b idx=%0d fw=%h amp=%h ph=%h, required 1 1 0 0 4000 0 0",
                     res_valid, res_err, meas_req, res_idx, res_fword, res_amp, res_phase);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({fword_load, fword} !== {1'b1, 32'h4040}) begin
            failures++;
            $display("FAIL t4_continue: fword_load=%b fword=%h, required 1 4040", fword_load, fword);
        end
        @(negedge clk);
        meas_ack = 1'b1; meas_amp = 32'h77; meas_phase = 32'h88;
        @(negedge clk);
        meas_ack = 1'b0;
        checks++;
        if ({res_valid, res_err, res_idx, res_amp, res_phase} !== {1'b1, 1'b0, 16'd1, 32'h77, 32'h88}) begin
            failures++;
            $display("FAIL t4_result1: v=%b err=%b idx=%0d amp=%h ph=%h, required 1 0 1 77 88",
                     res_valid, res_err, res_idx, res_amp, res_phase);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL t4_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ef;
        res_ready = 1'b1;
        do_start(32'hFFFF_FF00, 32'h100, 16'd2, 24'd1);
        for (int p = 0; p < 2; p++) begin
            ef = (p == 0) ? 32'hFFFF_FF00 : 32'h0;
            @(negedge clk);
            checks++;
            if ({fword_load, fword} !== {1'b1, ef}) begin
                failures++;
                $display("FAIL t5_load%0d: fword_load=%b fword=%h, required 1 %h", p, fword_load, fword, ef);
            end
            repeat (2) @(negedge clk);
            meas_ack = 1'b1; meas_amp = 32'h5; meas_phase = 32'h6;
            @(negedge clk);
            meas_ack = 1'b0;
            checks++;
            if ({res_valid, res_idx, res_fword} !== {1'b1, 16'(p), ef}) begin
                failures++;
                $display("FAIL t5_result%0d: v=%b idx=%0d fw=%h, required 1 %0d %h",
                         p, res_valid, res_idx, res_fword, p, ef);
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL t5_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_abort();
        res_ready = 1'b1;
        do_start(32'h6000, 32'h1, 16'd3, 24'd8);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({aborted, busy, meas_req, res_valid, done} !== 5'b10000) begin
            failures++;
            $display("FAIL t6_abort_settle: aborted=%b busy=%b req=%b v=%b done=%b, required 1 0 0 0 0",
                     aborted, busy, meas_req, res_valid, done);
        end
        @(negedge clk);
        checks++;
        if ({aborted, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL t6_abort_pulse: aborted=%b busy=%b done=%b, required 0 0 0", aborted, busy, done);
        end

        res_ready = 1'b0;
        do_start(32'h6100, 32'h1, 16'd2, 24'd0);
        repeat (2) @(negedge clk);
        meas_ack = 1'b1; meas_amp = 32'h9; meas_phase = 32'h9;
        @(negedge clk);
        meas_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL t6_out_valid: res_valid=%b, required 1", res_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({aborted, res_valid, busy, done} !== 4'b1000) begin
            failures++;
            $display("FAIL t6_abort_out: aborted=%b v=%b busy=%b done=%b, required 1 0 0 0",
                     aborted, res_valid, busy, done);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({aborted, done} !== 2'b00) begin
            failures++;
            $display("FAIL t6_abort_idle: aborted=%b done=%b, required 0 0", aborted, done);
        end

        res_ready = 1'b1;
        abort = 1'b1;
        do_start(32'h6200, 32'h10, 16'd1, 24'd0);
        abort = 1'b0;
        checks++;
        if ({busy, aborted} !== 2'b10) begin
            failures++;
            $display("FAIL t6_start_abort: busy=%b aborted=%b, required 1 0", busy, aborted);
        end
        @(negedge clk);
        checks++;
        if ({fword_load, fword} !== {1'b1, 32'h6200}) begin
            failures++;
            $display("FAIL t6_restart_load: fword_load=%b fword=%h, required 1 6200", fword_load, fword);
        end
        @(negedge clk);
        meas_ack = 1'b1; meas_amp = 32'h3; meas_phase = 32'h4;
        @(negedge clk);
        meas_ack = 1'b0;
        checks++;
        if ({res_valid, res_idx, res_fword, res_amp} !== {1'b1, 16'd0, 32'h6200, 32'h3}) begin
            failures++;
            $display("FAIL t6_restart_result: v=%b idx=%0d fw=%h amp=%h, required 1 0 6200 3",
                     res_valid, res_idx, res_fword, res_amp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({done, aborted, busy} !== 3'b100) begin
            failures++;
            $display("FAIL t6_restart_done: done=%b aborted=%b busy=%b, required 1 0 0", done, aborted, busy);
        end
    endtask

    task automatic test_async_reset();
        res_ready = 1'b1;
        do_start(32'h7000, 32'h1, 16'd2, 24'd5);
        @(negedge clk);
        checks++;
        if ({fword_load, fword} !== {1'b1, 32'h7000}) begin
            failures++;
            $display("FAIL ar_load: fword_load=%b fword=%h, required 1 7000", fword_load, fword);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, fword_load, meas_req} !== 3'b000 || fword !== 32'h0) begin
            failures++;
            $display("FAIL ar_immediate: busy=%b load=%b req=%b fword=%h, required 0 0 0 0",
                     busy, fword_load, meas_req, fword);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, fword_load, meas_req} !== 3'b000) begin
            failures++;
            $display("FAIL ar_stays_idle: busy=%b load=%b req=%b, required 0 0 0", busy, fword_load, meas_req);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_step = '0; n_points = '0; settle_cyc = '0;
        meas_ack = 1'b0; meas_amp = '0; meas_phase = '0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_points();
        test_backpressure();
        test_timeout();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
